// File: rtl/adder_4b.sv
// adder_4b: registered unsigned ripple-carry adder, carry-out in the result MSB
module adder_4b #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_sum
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;
  assign c[0] = 1'b0;
  for (genvar k = 0; k < WIDTH; k++) begin : g_fa
    assign s[k]   = i_a[k] ^ i_b[k] ^ c[k];
    assign c[k+1] = (i_a[k] & i_b[k]) | (c[k] & (i_a[k] ^ i_b[k]));
  end
  always_comb sum_d = {c[WIDTH], s};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) sum_q <= '0;
    else sum_q <= sum_d;
  assign o_sum = sum_q;
endmodule

// File: tb/tb_adder_4b.sv
// tb_adder_4b: directed and randomized checks of adder_4b at WIDTH=4 and WIDTH=8
module tb_adder_4b;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a4, b4;
  logic [4:0] s4;
  logic [7:0] a8, b8;
  logic [8:0] s8;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_4b #(.WIDTH(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .i_a(a4), .i_b(b4), .o_sum(s4));
  adder_4b #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .i_a(a8), .i_b(b8), .o_sum(s8));

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sum is plain integer addition of the two unsigned operands.
  task automatic step4(input string tag, input int a, input int b);
    @(negedge clk);
    a4 = 4'(a);
    b4 = 4'(b);
    @(posedge clk);
    #1 chk(tag, {4'b0, s4}, 9'(a + b));
  endtask

  task automatic step8(input string tag, input int a, input int b);
    @(negedge clk);
    a8 = 8'(a);
    b8 = 8'(b);
    @(posedge clk);
    #1 chk(tag, s8, 9'(a + b));
  endtask

  initial begin
    rst_n = 1'b0;
    a4 = 4'hF;
    b4 = 4'hF;
    a8 = 8'hFF;
    b8 = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1 chk("reset_hold4", {4'b0, s4}, 9'h0);
      chk("reset_hold8", s8, 9'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step4("basic_1_1", 1, 1);
    step4("basic_0_1", 0, 1);
    step4("basic_0_0", 0, 0);
    step4("max_carry", 15, 15);
    step4("ripple_f_1", 15, 1);
    step8("w8_ff_ff", 255, 255);
    step8("w8_ff_01", 255, 1);
    step4("hold_load", 15, 15);
    #2;
    a4 = 4'h3;
    b4 = 4'h4;
    #1 chk("hold_midcycle", {4'b0, s4}, 9'h1E);
    @(posedge clk);
    #1 chk("hold_next_edge", {4'b0, s4}, 9'h07);
    step4("pre_async", 15, 15);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("async_reset4", {4'b0, s4}, 9'h0);
    chk("async_reset8", s8, 9'h0);
    @(posedge clk);
    #1 chk("reset_wins", {4'b0, s4}, 9'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        step4("exhaustive4", i, j);
    for (int n = 0; n < 300; n++)
      step8("random8", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
